// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry posted-write FIFO that drains into a full-word data_memory by read-modify-write.
// Define STORE_BUF_FWD_EN to forward pending store bytes to loads; otherwise matching loads wait for drain.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [3:0]    st_be,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_ready,
  output logic [31:0]   ld_data,
  output logic [31:0]   mem_A,
  output logic [31:0]   mem_WD,
  output logic          mem_WE,
  input  logic [31:0]   mem_RD,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;

  logic [DEPTH-1:0] valid_q;
  logic [WW-1:0]    word_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             alive_q;

  logic [DEPTH-1:0] valid_d;
  logic [PW-1:0]    head_d;
  logic [PW-1:0]    tail_d;
  logic [CW-1:0]    count_d;

  logic [PW-1:0]    slot_s [DEPTH];
  logic             hit_s;
  logic [WW-1:0]    ld_word_s;
  logic [31:0]      ld_word_data_s;
  logic [31:0]      drain_wd_s;
  logic             full_s;
  logic             push_s;
  logic             ld_ok_s;
  logic             drain_s;
`ifndef STORE_BUF_FWD_EN
  logic             ld_match_s;
`endif

  // Byte offsets are ignored: everything here is word-granular
  logic unused_s;
  assign unused_s = ^{st_addr[1:0], ld_addr[1:0]};

  // Scan pending entries oldest to youngest so the youngest matching byte wins
  always_comb begin
    ld_word_s      = ld_addr[AW-1:2];
    hit_s          = 1'b0;
    ld_word_data_s = mem_RD;
`ifndef STORE_BUF_FWD_EN
    ld_match_s     = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      slot_s[i] = head_q + PW'(i);
      hit_s     = (CW'(i) < count_q) && valid_q[slot_s[i]] &&
                  (word_q[slot_s[i]] == ld_word_s);
`ifdef STORE_BUF_FWD_EN
      for (int k = 0; k < 4; k++) begin
        ld_word_data_s[8*k +: 8] = (hit_s && be_q[slot_s[i]][k]) ?
                                   data_q[slot_s[i]][8*k +: 8] : ld_word_data_s[8*k +: 8];
      end
`else
      ld_match_s = ld_match_s || hit_s;
`endif
    end
  end

  // Port arbitration: full buffer drains first, then loads, then background drain
  always_comb begin
    full_s   = (count_q == CW'(DEPTH));
    st_ready = alive_q && !full_s;
    push_s   = st_valid && st_ready && (st_be != 4'b0000);
`ifdef STORE_BUF_FWD_EN
    ld_ok_s  = ld_valid && !full_s;
`else
    ld_ok_s  = ld_valid && !full_s && !ld_match_s;
`endif
    drain_s  = !ld_ok_s && (count_q != CW'(0));

    for (int k = 0; k < 4; k++) begin
      drain_wd_s[8*k +: 8] = be_q[head_q][k] ? data_q[head_q][8*k +: 8] : mem_RD[8*k +: 8];
    end

    ld_ready = ld_ok_s;
    ld_data  = ld_ok_s ? ld_word_data_s : 32'h0000_0000;
    mem_WE   = drain_s;
    mem_WD   = drain_s ? drain_wd_s : 32'h0000_0000;
    if (drain_s) begin
      mem_A = 32'(word_q[head_q]);
    end else if (ld_ok_s) begin
      mem_A = 32'(ld_word_s);
    end else begin
      mem_A = 32'h0000_0000;
    end
    empty = (count_q == CW'(0));

    for (int j = 0; j < DEPTH; j++) begin
      valid_d[j] = (push_s && (tail_q == PW'(j))) ? 1'b1 :
                   (drain_s && (head_q == PW'(j))) ? 1'b0 : valid_q[j];
    end
    head_d  = drain_s ? head_q + PW'(1) : head_q;
    tail_d  = push_s  ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push_s) - CW'(drain_s);
  end

  // Control state; reset drops every pending entry without touching memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alive_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alive_q <= 1'b1;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    if (push_s) begin
      word_q[tail_q] <= st_addr[AW-1:2];
      data_q[tail_q] <= st_data;
      be_q[tail_q]   <= st_be;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: table vectors, directed corner sequences and random traffic vs a queue model.
// Expectations follow STORE_BUF_FWD_EN the same way the design does.
`timescale 1ns/1ps
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int MW    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic [31:0]   mem_A;
  logic [31:0]   mem_WD;
  logic          mem_WE;
  logic [31:0]   mem_RD;
  logic          empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD), .empty(empty)
  );

  // data_memory model (physical) and program-order view of memory (architectural)
  logic [31:0] mem  [MW];
  logic [31:0] arch [MW];
  assign mem_RD = mem[mem_A[5:0]];

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];
  logic alive;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_load, exp_drain, exp_push;
  logic cap_we;
  logic [31:0] cap_a, cap_wd;

  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        e_st_ready;
    logic        e_ld_ready;
    logic        e_we;
    logic        e_empty;
    logic [31:0] e_a;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd, input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? nd[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the queue model, just before the coming edge
  task automatic probe();
    logic        match;
    logic [29:0] lw;
    logic [31:0] ea;
    #3;
    lw    = ld_addr[31:2];
    match = 1'b0;
    foreach (q[i]) if (q[i].word == lw) match = 1'b1;
    exp_load = ld_valid && (q.size() < DEPTH);
`ifndef STORE_BUF_FWD_EN
    if (match) exp_load = 1'b0;
`endif
    exp_drain = !exp_load && (q.size() > 0);
    exp_push  = alive && (q.size() < DEPTH) && st_valid && (st_be != 4'b0000);
    ea = exp_drain ? 32'(q[0].word) : (exp_load ? 32'(lw) : 32'h0);
    chk("st_ready", {31'b0, st_ready}, {31'b0, alive && (q.size() < DEPTH)});
    chk("empty",    {31'b0, empty},    {31'b0, q.size() == 0});
    chk("ld_ready", {31'b0, ld_ready}, {31'b0, exp_load});
    chk("mem_WE",   {31'b0, mem_WE},   {31'b0, exp_drain});
    chk("mem_A", mem_A, ea);
    if (exp_load)  chk("ld_data", ld_data, arch[lw[5:0]]);
    if (exp_drain) chk("mem_WD", mem_WD, merge(mem[q[0].word[5:0]], q[0].data, q[0].be));
    cap_we = mem_WE;
    cap_a  = mem_A;
    cap_wd = mem_WD;
  endtask

  // Advance one edge: memory write, then model pop/push
  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (cap_we) mem[cap_a[5:0]] = cap_wd;
    if (!reset) begin
      q.delete();
      alive = 1'b0;
    end else begin
      if (exp_drain) void'(q.pop_front());
      if (exp_push) begin
        e.word = st_addr[31:2];
        e.data = st_data;
        e.be   = st_be;
        q.push_back(e);
        arch[e.word[5:0]] = merge(arch[e.word[5:0]], st_data, st_be);
      end
      alive = 1'b1;
    end
    #1;
  endtask

  task automatic cyc();
    probe();
    tick();
  endtask

  task automatic set_in(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [3:0] sb, input logic lv, input logic [31:0] la);
    st_valid = sv; st_addr = sa; st_data = sd; st_be = sb; ld_valid = lv; ld_addr = la;
  endtask

  task automatic drain_all();
    set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (q.size() == 0) break;
      cyc();
    end
    probe();
    chk("drain_done", {31'b0, empty}, 32'h1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap [MW];
    logic        got;
    int          bad;

    for (int i = 0; i < MW; i++) begin
      mem[i]  = $urandom;
      arch[i] = mem[i];
    end
    alive = 1'b0;
    reset = 1'b0;
    set_in(1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    #1;

    // Reset held with a store request pending
    probe();
    chk("rst_st_ready", {31'b0, st_ready}, 32'h0);
    chk("rst_mem_WE",   {31'b0, mem_WE},   32'h0);
    chk("rst_empty",    {31'b0, empty},    32'h1);
    chk("rst_mem_WD",   mem_WD,            32'h0);
    tick();
    reset = 1'b1;
    cyc();
    st_valid = 1'b0;
    probe();
    chk("release_st_ready", {31'b0, st_ready}, 32'h1);
    tick();

    // Table: partial store, RMW drain, discarded be=0 store, plain load
    mem[5] = 32'h11223344; arch[5] = 32'h11223344;
    tbl[0] = '{1'b1, 32'h14, 32'h0000AA00, 4'b0010, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,         32'h0};
    tbl[1] = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h5, 32'h1122AA44,  32'h0};
    tbl[2] = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,         32'h0};
    tbl[3] = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,         32'h0};
    tbl[4] = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,         32'h0};
    tbl[5] = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b1, 32'h17, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5, 32'h0,         32'h1122AA44};
    for (int r = 0; r < 6; r++) begin
      set_in(tbl[r].st_valid, tbl[r].st_addr, tbl[r].st_data, tbl[r].st_be, tbl[r].ld_valid, tbl[r].ld_addr);
      probe();
      chk("tbl_st_ready", {31'b0, st_ready}, {31'b0, tbl[r].e_st_ready});
      chk("tbl_ld_ready", {31'b0, ld_ready}, {31'b0, tbl[r].e_ld_ready});
      chk("tbl_mem_WE",   {31'b0, mem_WE},   {31'b0, tbl[r].e_we});
      chk("tbl_empty",    {31'b0, empty},    {31'b0, tbl[r].e_empty});
      chk("tbl_mem_A",    mem_A,             tbl[r].e_a);
      if (tbl[r].e_we)       chk("tbl_mem_WD",  mem_WD,  tbl[r].e_wd);
      if (tbl[r].e_ld_ready) chk("tbl_ld_data", ld_data, tbl[r].e_ld);
      tick();
    end

    // Two byte stores to one word under a continuous load stream
    mem[5] = 32'h11223344; arch[5] = 32'h11223344;
    set_in(1'b1, 32'h14, 32'h000000BB, 4'b0001, 1'b1, 32'h14);
    probe();
    chk("fwd_c0_ld_data", ld_data, 32'h11223344);
    tick();
    set_in(1'b1, 32'h14, 32'h000000CC, 4'b0001, 1'b1, 32'h14);
    cyc();
    st_valid = 1'b0;
    probe();
`ifdef STORE_BUF_FWD_EN
    chk("fwd_ld_ready", {31'b0, ld_ready}, 32'h1);
    chk("fwd_ld_data",  ld_data,           32'h112233CC);
`else
    chk("nofwd_ld_stall", {31'b0, ld_ready}, 32'h0);
`endif
    tick();
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      probe();
      if (ld_ready) begin
        chk("fwd_final_ld_data", ld_data, 32'h112233CC);
        got = 1'b1;
        tick();
        break;
      end
      tick();
    end
    chk("fwd_load_served", {31'b0, got}, 32'h1);
    drain_all();

    // Fill to DEPTH while loads of an unrelated word keep the port busy
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'(4 * i), $urandom, 4'hF, 1'b1, 32'h40);
      cyc();
    end
    set_in(1'b1, 32'h10, 32'h5555AAAA, 4'hF, 1'b1, 32'h40);
    probe();
    chk("full_st_ready", {31'b0, st_ready}, 32'h0);
    chk("full_ld_ready", {31'b0, ld_ready}, 32'h0);
    chk("full_mem_WE",   {31'b0, mem_WE},   32'h1);
    tick();
    probe();
    chk("full_st_ready_back", {31'b0, st_ready}, 32'h1);
    chk("full_ld_ready_back", {31'b0, ld_ready}, 32'h1);
    tick();
    drain_all();

    // Reset with three stores pending
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(8 + 4 * i), $urandom, 4'hF, 1'b1, 32'h40);
      cyc();
    end
    for (int i = 0; i < MW; i++) snap[i] = mem[i];
    set_in(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    chk("midrst_empty",  {31'b0, empty},  32'h1);
    chk("midrst_mem_WE", {31'b0, mem_WE}, 32'h0);
    q.delete();
    alive = 1'b0;
    for (int i = 0; i < MW; i++) arch[i] = mem[i];
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    bad = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== snap[i]) bad++;
    chk("midrst_mem_unchanged", 32'(bad), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), {24'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
             $urandom, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 2) != 0), {24'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
      cyc();
    end
    drain_all();
    for (int i = 0; i < MW; i++) chk("final_mem", mem[i], arch[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's load/store path and `data_memory`. Accepts byte-enabled stores in one cycle and queues them in a DEPTH-entry FIFO. Drains them into the word-wide, full-word-write `data_memory` port by read-modify-write, and forwards pending store bytes to loads. Sole owner of the `data_memory` A/WD/WE port.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `AW`, 32: byte-address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `st_valid`  in  1  store request.
- `st_ready`  out  1  buffer can accept a store.
- `st_addr`  in  AW  store byte address; [1:0] ignored.
- `st_data`  in  32  store data, lane-aligned (byte k on [8k+7:8k]).
- `st_be`  in  4  byte enables; 4'b0000 is accepted and discarded (no entry).
- `ld_valid`  in  1  load request.
- `ld_addr`  in  AW  load byte address; [1:0] ignored, full word returned.
- `ld_ready`  out  1  `ld_data` valid this cycle.
- `ld_data`  out  32  load word.
- `mem_A`  out  32  to `data_memory` A; word index {2'b00, addr[AW-1:2]}.
- `mem_WD`  out  32  to `data_memory` WD.
- `mem_WE`  out  1  to `data_memory` WE.
- `mem_RD`  in  32  from `data_memory` RD (combinational read).
- `empty`  out  1  no pending stores (fence/ecall use).

## Operation
- Storage: per entry valid, word address, 32-bit data, 4-bit be. Head/tail pointers log2(DEPTH) bits plus count 0..DEPTH; pointers wrap modulo DEPTH.
- Push: `st_valid && st_ready && st_be != 0` at an edge writes entry at tail, tail+1, count+1.
- Port arbitration per cycle (priority order):
  1. count == DEPTH: DRAIN. Load stalled (`ld_ready`=0).
  2. `ld_valid` and load permitted: LOAD. `mem_A` = load word, `mem_WE`=0.
  3. count > 0: DRAIN.
  4. Otherwise IDLE: `mem_A` = 0, `mem_WE` = 0.
- DRAIN: `mem_A` = head word; `mem_WD` byte k = head.be[k] ? head.data byte k : `mem_RD` byte k; `mem_WE`=1. At edge: head+1, count−1, entry invalidated.
- LOAD: `ld_data` byte k = youngest valid entry with matching word and be[k] set, else `mem_RD` byte k. A store pushed in the same cycle is not forwarded; it is visible from the next cycle.
- `st_ready` = (count < DEPTH) from registered count. Push and drain in the same cycle leave count unchanged.
- `empty` = (count == 0).
- Reset mid-operation discards all pending entries; no partial write is issued.

## Timing
- Reset values: `st_ready`=0 while reset asserted, 1 from the first cycle after deassertion. `ld_ready`=0, `mem_WE`=0, `mem_A`=0, `mem_WD`=0, `empty`=1, count/pointers=0.
- Store: accepted at edge N, earliest memory write at edge N+1 (DRAIN in cycle N+1).
- Load: combinational, zero cycles; `ld_ready` held 0 only under full-buffer priority, or (macro off) on address match.
- Back-to-back stores sustain one per cycle while no loads contend. A continuous load stream drains only when full, so no starvation.
- `ld_ready`=0 whenever `ld_valid`=0.

## Configuration
- `STORE_BUF_FWD_EN` defined: byte forwarding as above.
- Undefined: no forwarding mux. A load whose word matches any valid entry is not permitted: `ld_ready`=0 and the cycle is DRAIN until no matching entry remains. Non-matching loads proceed normally.

## Test plan
- Reset: hold `reset`=0 with `st_valid`=1 → `st_ready`=0, `mem_WE`=0, `empty`=1. Release → `st_ready`=1 next cycle.
- Partial store: mem[5]=32'h11223344; store addr 0x14, data 32'h0000AA00, be 4'b0010, no loads → one cycle later `mem_WE`=1, `mem_A`=5, `mem_WD`=32'h1122AA44; `empty`=1 afterwards.
- Forwarding (macro on): stores be 4'b0001 data 0x000000BB and be 4'b0001 data 0x000000CC to 0x14, with continuous loads of 0x14 → `ld_ready`=1 and `ld_data`=32'h112233CC on the cycle after the second push.
- Full: DEPTH=4, 4 stores with loads every cycle → `st_ready`=0 after the 4th push; load stalled one cycle while head drains; `st_ready`=1 next cycle.
- Macro off: same load as forwarding test → `ld_ready`=0 until both entries are drained, then `ld_data`=32'h112233CC from memory.
- Reset mid-operation: 3 pending stores, assert `reset` → `empty`=1 immediately, no `mem_WE` pulses, memory unchanged.
